uart_rcv: RTL and testbench
===========================

# uart_rcv

Serial UART receiver with 16× oversampling, 8 data bits LSB-first and one even-parity bit. It converts the RxD line into a byte presented zero-extended on a 32-bit bus. It raises RxRDY with a parity-error flag when a frame completes. It sits behind the CPU's memory-mapped UART and is read via the RD strobe.

## Interface
- OVERSAMPLE, 16: Clock cycles per bit period; must be even and ≥4.
- Clock  input  1  sole clock, rising-edge; runs at OVERSAMPLE × baud.
- Reset  input  1  synchronous, active-high; sampled on the Clock rising edge.
- RxD  input  1  serial line; idle high.
- RD  input  1  read strobe; sampled high on a Clock edge, it clears RxRDY and RxParityErr.
- RxRDY  output  1  received byte valid on Dout.
- RxParityErr  output  1  parity mismatch on the frame now held; valid while RxRDY=1.
- Dout  output  32  {24'b0, received byte}.

## Operation
- Frame format: start bit (0), D[0]..D[7] LSB first, parity bit. Stop bit is not required; the frame completes at the parity sample.
- The FSM has five states.
  - IDLE: when RxD=0 on an edge, go to START and reset the tick counter to 1.
  - START: count ticks. At tick OVERSAMPLE/2 (mid-bit), RxD=0 confirms the start bit: go to DATA. RxD=1 is a false start: go back to IDLE.
  - DATA: sample RxD every OVERSAMPLE ticks after the start mid-point. Shift the sample into bit index 0..7, LSB first. After bit 7, go to PARITY.
  - PARITY: sample the parity bit OVERSAMPLE ticks after D[7], then go to WAIT_HIGH.
  - WAIT_HIGH: stay until RxD=1 is sampled, then go to IDLE. A low parity bit is never taken as a new start bit.
- At the parity sample, on the same edge:
  - Dout[7:0] ← shifted byte and Dout[31:8] ← 0.
  - RxRDY ← 1.
  - RxParityErr ← (^data) ^ parity_bit, even parity.
- Dout holds its value until the next frame completes.
- RxRDY/RxParityErr are cleared by RD=1 on an edge.
- They are also cleared when a start bit is confirmed in START, so an unread byte is overwritten with no overrun flag.
- RD has no effect on the FSM or Dout.
- Reset sets state IDLE, counters 0, Dout=0, RxRDY=0, RxParityErr=0. Reset mid-frame abandons the frame.

## Timing
- Let edge 1 be the first edge that sees RxD=0 in IDLE. Counting from edge 1:
  - start confirmed at edge OVERSAMPLE/2 (8);
  - D[i] sampled at edge 8+16·(i+1);
  - parity sampled at edge 152.
- RxRDY rises after edge 152, inside the parity bit period. Dout is valid in that same cycle.
- RD clear latency is 1 edge. RD and a frame completion on the same edge: completion wins, RxRDY=1.
- RD and a start confirmation on the same edge: RxRDY=0.
- A false start costs OVERSAMPLE/2 cycles before returning to IDLE.

## Configuration
- UART_RCV_ODD_PARITY_EN
  - Defined: RxParityErr = ~((^data) ^ parity_bit), i.e. odd parity.
  - Undefined (default): even parity as described above.
  - Frame timing is identical either way.

## Test plan
- Reset, then RxD=1 for 32 clocks → RxRDY=0, RxParityErr=0, Dout=0.
- Frame start 0, data 8'b10011101 (LSB first: 1,0,1,1,1,0,0,1), parity 1, 16 clocks/bit → RxRDY=1 by clock 152, Dout=32'h0000009D, RxParityErr=0.
- Read and repeat:
  - RD=1 for one edge → RxRDY=0.
  - RxD=1 for 16 clocks, then frame data 8'b10011001, parity 0 → Dout=32'h00000099, RxRDY=1, RxParityErr=0.
  - Line held low after parity → no new frame starts until RxD returns high.
- Data 8'h9D with parity 0 → RxRDY=1, RxParityErr=1. The same frame with UART_RCV_ODD_PARITY_EN defined → RxParityErr=0.
- RxD low for 4 clocks, then high (glitch) → no frame, RxRDY stays 0, FSM back in IDLE by clock 8.
- Reset asserted at clock 60 of a frame → all outputs 0. The next full frame 8'h5A with parity 0 → Dout=32'h5A, RxParityErr=0.

Source files
------------

// File: rtl/uart_rcv.sv
// ---------------------------------------------------------------------------
// uart_rcv
//
// Serial UART receiver, OVERSAMPLE x oversampled, 8 data bits LSB first
// followed by one parity bit. No stop bit is required: the frame completes
// on the parity sample, after which the receiver waits for the line to
// return high before it will look for a new start bit.
//
// Parameters
//   OVERSAMPLE   clock cycles per bit period (even, >= 4)
//
// Ports
//   Clock        in   1   rising-edge clock, OVERSAMPLE x baud
//   Reset        in   1   synchronous active-high reset
//   RxD          in   1   serial line, idle high
//   RD           in   1   read strobe, clears RxRDY / RxParityErr
//   RxRDY        out  1   received byte valid on Dout
//   RxParityErr  out  1   parity mismatch on the held byte
//   Dout         out  32  {24'b0, received byte}
//
// Build option
//   UART_RCV_ODD_PARITY_EN  defined: odd parity check; undefined: even.
// ---------------------------------------------------------------------------
module uart_rcv #(
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic        RxD,
   input  logic        RD,
   output logic        RxRDY,
   output logic        RxParityErr,
   output logic [31:0] Dout
);

   localparam int unsigned CW = $clog2(OVERSAMPLE);

   localparam logic [CW-1:0] CNT_ZERO = '0;
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   // START is entered with the counter already at 1 (the detecting edge
   // counts as tick 1), so mid-bit is reached when it reads HALF-1.
   localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
   // DATA/PARITY restart the counter at 0 on each sample edge, so the
   // next sample lands when it reads OVERSAMPLE-1.
   localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_PARITY    = 3'd3;
   localparam logic [2:0] S_WAIT_HIGH = 3'd4;

   logic [2:0]    r_state;
   logic [CW-1:0] r_cnt;
   logic [2:0]    r_bitidx;
   logic [7:0]    r_shift;
   logic [7:0]    r_byte;
   logic          r_rdy;
   logic          r_perr;

   logic          w_mid;
   logic          w_full;
   logic          w_perr;

   always_comb begin
      w_mid  = (r_cnt == HALF_M1);
      w_full = (r_cnt == FULL_M1);
      // RxD is the parity bit on the edge where this value is used.
`ifdef UART_RCV_ODD_PARITY_EN
      w_perr = ~((^r_shift) ^ RxD);
`else
      w_perr = (^r_shift) ^ RxD;
`endif
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state  <= S_IDLE;
         r_cnt    <= CNT_ZERO;
         r_bitidx <= 3'd0;
         r_shift  <= 8'd0;
         r_byte   <= 8'd0;
         r_rdy    <= 1'b0;
         r_perr   <= 1'b0;
      end else begin
         // Read clear first; later assignments in the FSM (frame
         // completion) take priority on the same edge.
         if (RD) begin
            r_rdy  <= 1'b0;
            r_perr <= 1'b0;
         end

         case (r_state)
            S_IDLE: begin
               if (!RxD) begin
                  r_state <= S_START;
                  r_cnt   <= CNT_ONE;
               end
            end

            S_START: begin
               if (w_mid) begin
                  r_cnt <= CNT_ZERO;
                  if (!RxD) begin
                     // Confirmed start drops any unread byte's flags.
                     r_state  <= S_DATA;
                     r_bitidx <= 3'd0;
                     r_rdy    <= 1'b0;
                     r_perr   <= 1'b0;
                  end else begin
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            S_DATA: begin
               if (w_full) begin
                  r_cnt   <= CNT_ZERO;
                  r_shift <= {RxD, r_shift[7:1]};
                  if (r_bitidx == 3'd7) begin
                     r_state <= S_PARITY;
                  end else begin
                     r_bitidx <= r_bitidx + 3'd1;
                  end
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            S_PARITY: begin
               if (w_full) begin
                  r_cnt   <= CNT_ZERO;
                  r_byte  <= r_shift;
                  r_rdy   <= 1'b1;
                  r_perr  <= w_perr;
                  r_state <= S_WAIT_HIGH;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end

            S_WAIT_HIGH: begin
               // A low parity bit (or stuck-low line) must not look like
               // a new start bit.
               if (RxD) begin
                  r_state <= S_IDLE;
               end
            end

            default: begin
               r_state <= S_IDLE;
               r_cnt   <= CNT_ZERO;
            end
         endcase
      end
   end

   assign RxRDY       = r_rdy;
   assign RxParityErr = r_perr;
   assign Dout        = {24'd0, r_byte};

endmodule

// File: tb/tb_uart_rcv.sv
// ---------------------------------------------------------------------------
// tb_uart_rcv
//
// Self-checking bench for uart_rcv (OVERSAMPLE=16). Frames are driven bit by
// bit with edges numbered from the first edge that sees the start bit; the
// per-edge outputs are recorded and compared against expectations derived
// from the frame timing rules (confirm at OS/2, completion at 8+16*9).
// Define UART_RCV_ODD_PARITY_EN for both files to check the odd-parity build.
// ---------------------------------------------------------------------------
module tb_uart_rcv;

   localparam int OS      = 16;
   localparam int NEDGE   = OS * 10;
   localparam int E_CONF  = OS / 2;
   localparam int E_DONE  = OS / 2 + OS * 9;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        RxD   = 1'b1;
   logic        RD    = 1'b0;
   logic        RxRDY;
   logic        RxParityErr;
   logic [31:0] Dout;

   int checks   = 0;
   int failures = 0;

   logic        obs_rdy  [1:NEDGE];
   logic        obs_perr [1:NEDGE];
   logic [31:0] obs_dout [1:NEDGE];

   uart_rcv #(.OVERSAMPLE(OS)) dut (
      .Clock       (Clock),
      .Reset       (Reset),
      .RxD         (RxD),
      .RD          (RD),
      .RxRDY       (RxRDY),
      .RxParityErr (RxParityErr),
      .Dout        (Dout)
   );

   always #5 Clock = ~Clock;

   function automatic logic exp_perr(input logic [7:0] d, input logic p);
      int ones;
      ones = $countones(d) + int'(p);
`ifdef UART_RCV_ODD_PARITY_EN
      return (ones % 2) == 0;
`else
      return (ones % 2) == 1;
`endif
   endfunction

   task automatic idle(input int n, input bit rd_first);
      RxD = 1'b1;
      for (int i = 0; i < n; i++) begin
         RD = (i == 0) && rd_first;
         @(posedge Clock); #1;
         RD = 1'b0;
      end
   endtask

   // Drives one frame; stops right after reset_edge when it is nonzero.
   task automatic drive_frame(input logic [7:0] d, input logic p,
                              input int rd_edge, input bit hold_low,
                              input int reset_edge);
      logic [9:0] bits;
      bits = {p, d, 1'b0};
      for (int e = 1; e <= NEDGE; e++) begin
         RxD   = bits[(e - 1) / OS];
         RD    = (e == rd_edge);
         Reset = (e == reset_edge);
         @(posedge Clock); #1;
         RD    = 1'b0;
         Reset = 1'b0;
         obs_rdy[e]  = RxRDY;
         obs_perr[e] = RxParityErr;
         obs_dout[e] = Dout;
         if (e == reset_edge) break;
      end
      RxD = hold_low ? 1'b0 : 1'b1;
   endtask

   task automatic test_reset;
      Reset = 1'b1; RxD = 1'b1; RD = 1'b0;
      repeat (3) begin @(posedge Clock); #1; end
      Reset = 1'b0;
      idle(32, 0);
      checks++;
      if (RxRDY !== 1'b0) begin failures++; $display("FAIL reset_rdy got=%b exp=0", RxRDY); end
      checks++;
      if (RxParityErr !== 1'b0) begin failures++; $display("FAIL reset_perr got=%b exp=0", RxParityErr); end
      checks++;
      if (Dout !== 32'h0) begin failures++; $display("FAIL reset_dout got=%h exp=0", Dout); end
   endtask

   task automatic test_frame_9d;
      drive_frame(8'h9D, 1'b1, 0, 0, 0);
      checks++;
      if (obs_rdy[E_DONE-1] !== 1'b0) begin failures++; $display("FAIL f9d_rdy_early got=%b exp=0", obs_rdy[E_DONE-1]); end
      checks++;
      if (obs_rdy[E_DONE] !== 1'b1) begin failures++; $display("FAIL f9d_rdy got=%b exp=1", obs_rdy[E_DONE]); end
      checks++;
      if (obs_dout[E_DONE] !== 32'h0000009D) begin failures++; $display("FAIL f9d_dout got=%h exp=0000009d", obs_dout[E_DONE]); end
      checks++;
      if (obs_perr[E_DONE] !== exp_perr(8'h9D, 1'b1)) begin failures++; $display("FAIL f9d_perr got=%b exp=%b", obs_perr[E_DONE], exp_perr(8'h9D, 1'b1)); end
   endtask

   task automatic test_read_and_repeat;
      int drops;
      RxD = 1'b1; RD = 1'b1;
      @(posedge Clock); #1;
      RD = 1'b0;
      checks++;
      if (RxRDY !== 1'b0) begin failures++; $display("FAIL rd_clear got=%b exp=0", RxRDY); end
      checks++;
      if (Dout !== 32'h9D) begin failures++; $display("FAIL rd_dout_hold got=%h exp=9d", Dout); end
      idle(16, 0);
      drive_frame(8'h99, 1'b0, 0, 1, 0);
      checks++;
      if (obs_dout[E_DONE-1] !== 32'h9D) begin failures++; $display("FAIL f99_dout_before got=%h exp=9d", obs_dout[E_DONE-1]); end
      checks++;
      if (obs_rdy[E_DONE] !== 1'b1) begin failures++; $display("FAIL f99_rdy got=%b exp=1", obs_rdy[E_DONE]); end
      checks++;
      if (obs_dout[E_DONE] !== 32'h00000099) begin failures++; $display("FAIL f99_dout got=%h exp=00000099", obs_dout[E_DONE]); end
      checks++;
      if (obs_perr[E_DONE] !== exp_perr(8'h99, 1'b0)) begin failures++; $display("FAIL f99_perr got=%b exp=%b", obs_perr[E_DONE], exp_perr(8'h99, 1'b0)); end
      // Line stuck low: a restarted frame would clear RxRDY at its confirm.
      drops = 0;
      for (int i = 0; i < 3 * OS; i++) begin
         @(posedge Clock); #1;
         if (RxRDY !== 1'b1 || Dout !== 32'h99) drops++;
      end
      checks++;
      if (drops !== 0) begin failures++; $display("FAIL hold_low_no_restart got=%0d exp=0 disturbed cycles", drops); end
      idle(4, 0);
   endtask

   task automatic test_parity_error;
      // RD on the completion edge: completion wins.
      drive_frame(8'h9D, 1'b0, E_DONE, 0, 0);
      checks++;
      if (obs_rdy[E_DONE] !== 1'b1) begin failures++; $display("FAIL perr_rdy_vs_rd got=%b exp=1", obs_rdy[E_DONE]); end
      checks++;
      if (obs_perr[E_DONE] !== exp_perr(8'h9D, 1'b0)) begin failures++; $display("FAIL perr_flag got=%b exp=%b", obs_perr[E_DONE], exp_perr(8'h9D, 1'b0)); end
      checks++;
      if (obs_dout[E_DONE] !== 32'h9D) begin failures++; $display("FAIL perr_dout got=%h exp=9d", obs_dout[E_DONE]); end
      idle(3, 0);
   endtask

   task automatic test_overwrite;
      // Previous byte left unread; the confirm edge drops its flags.
      drive_frame(8'h3C, 1'b1, 0, 0, 0);
      checks++;
      if (obs_rdy[E_CONF-1] !== 1'b1) begin failures++; $display("FAIL ovw_rdy_pre got=%b exp=1", obs_rdy[E_CONF-1]); end
      checks++;
      if (obs_rdy[E_CONF] !== 1'b0) begin failures++; $display("FAIL ovw_rdy_conf got=%b exp=0", obs_rdy[E_CONF]); end
      checks++;
      if (obs_dout[E_DONE] !== 32'h3C) begin failures++; $display("FAIL ovw_dout got=%h exp=3c", obs_dout[E_DONE]); end
      idle(2, 1);
   endtask

   task automatic test_false_start;
      int bad;
      bad = 0;
      RxD = 1'b0;
      repeat (4) begin @(posedge Clock); #1; if (RxRDY !== 1'b0) bad++; end
      RxD = 1'b1;
      repeat (4) begin @(posedge Clock); #1; if (RxRDY !== 1'b0) bad++; end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL glitch_rdy got=%0d exp=0 high cycles", bad); end
      // Next edge must already be seen by IDLE for exact frame timing.
      drive_frame(8'hC3, 1'b0, 0, 0, 0);
      checks++;
      if (obs_rdy[E_DONE-1] !== 1'b0) begin failures++; $display("FAIL glitch_frame_early got=%b exp=0", obs_rdy[E_DONE-1]); end
      checks++;
      if (obs_rdy[E_DONE] !== 1'b1) begin failures++; $display("FAIL glitch_frame_rdy got=%b exp=1", obs_rdy[E_DONE]); end
      checks++;
      if (obs_dout[E_DONE] !== 32'hC3) begin failures++; $display("FAIL glitch_frame_dout got=%h exp=c3", obs_dout[E_DONE]); end
      idle(2, 0);
   endtask

   task automatic test_reset_midframe;
      drive_frame(8'h77, 1'b1, 0, 0, 60);
      checks++;
      if (obs_rdy[60] !== 1'b0 || obs_perr[60] !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b%b exp=00", obs_rdy[60], obs_perr[60]); end
      checks++;
      if (obs_dout[60] !== 32'h0) begin failures++; $display("FAIL midrst_dout got=%h exp=0", obs_dout[60]); end
      idle(10, 0);
      drive_frame(8'h5A, 1'b0, 0, 0, 0);
      checks++;
      if (obs_rdy[E_DONE] !== 1'b1) begin failures++; $display("FAIL f5a_rdy got=%b exp=1", obs_rdy[E_DONE]); end
      checks++;
      if (obs_dout[E_DONE] !== 32'h5A) begin failures++; $display("FAIL f5a_dout got=%h exp=5a", obs_dout[E_DONE]); end
      checks++;
      if (obs_perr[E_DONE] !== exp_perr(8'h5A, 1'b0)) begin failures++; $display("FAIL f5a_perr got=%b exp=%b", obs_perr[E_DONE], exp_perr(8'h5A, 1'b0)); end
      idle(2, 0);
   endtask

   task automatic test_random;
      logic [7:0]  d;
      logic        p;
      int          rd_edge;
      int          rd_pick [5] = '{0, E_CONF, 40, E_DONE, E_DONE + 3};
      logic        m_rdy;
      logic        m_perr;
      logic [31:0] m_dout;
      // Outputs after the preceding frame (5A, unread).
      m_rdy  = 1'b1;
      m_perr = exp_perr(8'h5A, 1'b0);
      m_dout = 32'h5A;
      for (int f = 0; f < 12; f++) begin
         d       = 8'($urandom);
         p       = 1'($urandom_range(0, 1));
         rd_edge = rd_pick[$urandom_range(0, 4)];
         drive_frame(d, p, rd_edge, 0, 0);
         for (int e = 1; e <= NEDGE; e++) begin
            if (e == rd_edge || e == E_CONF) begin m_rdy = 1'b0; m_perr = 1'b0; end
            if (e == E_DONE) begin m_rdy = 1'b1; m_perr = exp_perr(d, p); m_dout = {24'd0, d}; end
            checks++;
            if (obs_rdy[e] !== m_rdy || obs_perr[e] !== m_perr || obs_dout[e] !== m_dout) begin
               failures++;
               $display("FAIL rand_f%0d_e%0d got rdy=%b perr=%b dout=%h exp rdy=%b perr=%b dout=%h",
                        f, e, obs_rdy[e], obs_perr[e], obs_dout[e], m_rdy, m_perr, m_dout);
            end
         end
         idle($urandom_range(1, 20), 0);
      end
   endtask

   initial begin
      test_reset;
      test_frame_9d;
      test_read_and_repeat;
      test_parity_error;
      test_overwrite;
      test_false_start;
      test_reset_midframe;
      test_random;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
